// File: rtl/serial_full_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_full_adder_pkg;

    // Operand and sum width used when the top is instantiated without an override.
    localparam int DEFAULT_WIDTH = 8;

    // Controller states. The encoding is fixed so that state values stay stable
    // when someone probes them on a waveform or in a netlist.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_full_adder_pkg

// File: rtl/full_adder_cell.sv
// Single-bit full adder. The serial adder reuses this one cell on every bit.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule : full_adder_cell

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on start and added LSB-first,
// one bit per clock, through a single full-adder cell and a carry flip-flop.
// {cout, sum} is valid while done pulses and holds until the next accepted start.
module serial_full_adder
    import serial_full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    count;
    logic             cell_s;
    logic             cell_co;
    logic             last_bit;

    // The only arithmetic in the design: bit 0 of each operand plus the running carry.
    full_adder_cell u_cell (
        .a  (a_reg[0]),
        .b  (b_reg[0]),
        .c  (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last_bit = (count == LAST);

    // State register; a synchronous reset always returns the controller to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; start is only honoured in IDLE, DONE lasts one cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // leaves a signal unassigned, which would infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then shift one bit through the cell per clock.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is plain flops (no memory array), so clearing all of it
        // on reset is cheap and gives the zeroed outputs seen after an abort.
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        count <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    carry <= cell_co;
                    sum   <= {cell_s, sum[WIDTH-1:1]};
                    if (last_bit) begin
                        // Count parks at its last value; it is rearmed by the next start.
                        cout <= cell_co;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    // DONE: results hold.
                end
            endcase
        end
    end

endmodule : serial_full_adder

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: an 8-bit instance for directed, random,
// abort and back-to-back scenarios, and a 3-bit instance for an exhaustive sweep.
// Expected results come from plain integer addition of the operands.
module tb_serial_full_adder;

    localparam int W8 = 8;
    localparam int W3 = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          start8 = 1'b0;
    logic [W8-1:0] a8 = '0;
    logic [W8-1:0] b8 = '0;
    logic          cin8 = 1'b0;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] sum8;
    logic          cout8;

    logic          start3 = 1'b0;
    logic [W3-1:0] a3 = '0;
    logic [W3-1:0] b3 = '0;
    logic          cin3 = 1'b0;
    logic          busy3;
    logic          done3;
    logic [W3-1:0] sum3;
    logic          cout3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_full_adder #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_full_adder #(.WIDTH(W3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .cin   (cin3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3)
    );

    // Reference: the full (WIDTH+1)-bit sum of the operands.
    function automatic logic [W8:0] ref_add8(input logic [W8-1:0] x, input logic [W8-1:0] y, input logic c);
        return (W8+1)'(x) + (W8+1)'(y) + (W8+1)'(c);
    endfunction

    // Runs one 8-bit operation. j counts negedges after the accepting edge (j=1 is the
    // first cycle after it). Optionally pulses a stray start at cycle glitch_at.
    task automatic run8(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic cv,
                        input int glitch_at,
                        output logic [W8-1:0] s_o, output logic co_o,
                        output int busy_n, output int done_at, output int done_n, output bit held);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        s_o = '0; co_o = 1'b0; busy_n = 0; done_at = 0; done_n = 0; held = 1'b1;
        for (int j = 1; j <= W8 + 4; j++) begin
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = j;
                    s_o = sum8;
                    co_o = cout8;
                end
            end else if (done_at != 0 && (sum8 !== s_o || cout8 !== co_o)) begin
                held = 1'b0;
            end
            if (glitch_at != 0 && j == glitch_at) begin
                a8 = 8'h01; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (j < W8 + 4) @(negedge clk);
        end
    endtask

    // Full set of checks on one 8-bit operation against the reference model.
    task automatic check_op8(input string name, input logic [W8-1:0] av, input logic [W8-1:0] bv,
                             input logic cv, input int glitch_at);
        logic [W8-1:0] s;
        logic          co;
        int            busy_n, done_at, done_n;
        bit            held;
        logic [W8:0]   exp;
        exp = ref_add8(av, bv, cv);
        run8(av, bv, cv, glitch_at, s, co, busy_n, done_at, done_n, held);
        checks++;
        if ({co, s} !== exp) begin
            errors++;
            $display("FAIL %s result a=%h b=%h cin=%0d: got {cout,sum}=%h expected %h", name, av, bv, cv, {co, s}, exp);
        end
        checks++;
        if (done_at != W8 + 1 || done_n != 1) begin
            errors++;
            $display("FAIL %s done timing: got cycle %0d count %0d expected cycle %0d count 1", name, done_at, done_n, W8 + 1);
        end
        checks++;
        if (busy_n != W8) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n, W8);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s hold after done: outputs changed got %b expected 1", name, held);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0;
        start3 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8} !== '0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b expected all 0", busy8, done8, sum8, cout8);
        end
        checks++;
        if ({busy3, done3, sum3, cout3} !== '0) begin
            errors++;
            $display("FAIL reset3: got busy=%b done=%b sum=%h cout=%b expected all 0", busy3, done3, sum3, cout3);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        check_op8("basic_35_4a", 8'h35, 8'h4A, 1'b0, 0);
        check_op8("overflow_ff_01", 8'hFF, 8'h01, 1'b0, 0);
        check_op8("ones_cin_ignored_start", 8'hFF, 8'hFF, 1'b1, 3);
        check_op8("zero", 8'h00, 8'h00, 1'b0, 0);
        check_op8("zero_cin", 8'h00, 8'h00, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            check_op8("random", W8'($urandom), W8'($urandom), 1'($urandom), 0);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL abort pre-reset busy: got %b expected 1", busy8);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, sum8, cout8} !== '0) begin
            errors++;
            $display("FAIL abort outputs: got busy=%b done=%b sum=%h cout=%b expected all 0", busy8, done8, sum8, cout8);
        end
        done_seen = 0;
        for (int j = 0; j < W8 + 4; j++) begin
            @(negedge clk);
            if (done8 || busy8) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort activity: got %0d active cycles expected 0", done_seen);
        end
        check_op8("restart_10_20", 8'h10, 8'h20, 1'b0, 0);
    endtask

    task automatic test_rst_start_same_edge();
        @(negedge clk);
        rst = 1'b1; a8 = 8'h05; b8 = 8'h06; start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL rst_start busy: got %b expected 0", busy8);
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL rst_start later: got busy=%b done=%b expected 0 0", busy8, done8);
        end
    endtask

    task automatic test_exhaustive_w3();
        logic [6:0]    v;
        logic [W3:0]   exp;
        logic [W3-1:0] s;
        logic          co;
        int            lat;
        bit            found;
        for (int i = 0; i < 128; i++) begin
            v = 7'(i);
            @(negedge clk);
            a3 = v[2:0]; b3 = v[5:3]; cin3 = v[6]; start3 = 1'b1;
            exp = (W3+1)'(v[2:0]) + (W3+1)'(v[5:3]) + (W3+1)'(v[6]);
            @(negedge clk);
            start3 = 1'b0;
            found = 1'b0; lat = 0; s = '0; co = 1'b0;
            for (int j = 1; j <= W3 + 2; j++) begin
                if (done3 && !found) begin
                    found = 1'b1; lat = j; s = sum3; co = cout3;
                end
                @(negedge clk);
            end
            checks++;
            if (!found || lat != W3 + 1 || {co, s} !== exp) begin
                errors++;
                $display("FAIL w3 a=%0d b=%0d cin=%0d: got {cout,sum}=%0d at cycle %0d expected %0d at cycle %0d",
                         v[2:0], v[5:3], v[6], {co, s}, lat, exp, W3 + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W8:0] expq[$];
        logic [W8:0] exp;
        int          pushes, got, last;
        pushes = 0; got = 0; last = -1;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            if (done8) begin
                exp = (expq.size() != 0) ? expq.pop_front() : '0;
                checks++;
                if ({cout8, sum8} !== exp) begin
                    errors++;
                    $display("FAIL b2b result %0d: got %h expected %h", got, {cout8, sum8}, exp);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != W8 + 2) begin
                        errors++;
                        $display("FAIL b2b period: got %0d expected %0d", cyc - last, W8 + 2);
                    end
                end
                last = cyc;
                got++;
            end
            if (!busy8 && !done8 && pushes < 8) begin
                a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
                expq.push_back(ref_add8(a8, b8, cin8));
                start8 = 1'b1;
                pushes++;
            end else begin
                start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL b2b count: got %0d results expected 8", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_rst_start_same_edge();
        test_exhaustive_w3();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_full_adder
